tx_shift_and_hold_reg: RTL and testbench
========================================

# tx_shift_and_hold_reg

Transmit-side shift-and-hold register for the USB transceiver: it accepts parallel bytes through a one-entry hold register and serializes them LSB-first, one bit per bit-rate strobe. It sits between the packet/byte source and the NRZI encoder. It mirrors the receive shift-and-hold path, so a byte shifted out here is reassembled with the same bit order at the far end. It optionally inserts USB stuff bits.

## Interface

- DATA_W, 8, byte width; the block is specified for 8 only.

- tx_shift_and_hold_reg_Clk  in  1  single clock; all state changes on its rising edge.
- tx_shift_and_hold_reg_Rst  in  1  asynchronous, active-high reset.
- tx_shift_and_hold_reg_Data_In  in  8  parallel byte from the source.
- load_valid  in  1  source offers Data_In this cycle.
- load_ready  out  1  hold register is empty; equals !hold_full; reset value 1.
- tx_enable  in  1  bit-rate strobe; one serial bit period elapses per high cycle.
- tx_shift_and_hold_reg_Data_Out  out  1  serial bit; 0 whenever tx_active=0; reset value 0.
- tx_active  out  1  high while a data bit or stuff bit is on Data_Out; reset value 0.
- stuff_bit  out  1  high while the bit on Data_Out is an inserted stuff bit; reset value 0.

## Operation

- Hold register:
  - A load is accepted when load_valid=1 and load_ready=1.
  - On acceptance, hold=Data_In and hold_full=1.
  - hold_full clears on the edge where hold transfers into the shift register.
  - Acceptance and transfer never coincide, because load_ready is low while the hold register is full.
- State machine, states IDLE, SHIFT, STUFF:
  - **IDLE:** if hold_full=1, then sreg=hold, bit_cnt=0, hold_full=0, and the state goes to SHIFT. tx_enable is not required for this transfer.
  - **SHIFT:** Data_Out=sreg[0] and tx_active=1. When tx_enable=1, sreg shifts right, bit_cnt increments, and the bit just sent is retired.
  - **End of byte** (bit_cnt was 7 on the retiring tx_enable):
    - If hold_full=1, reload sreg from hold, set bit_cnt=0, and stay in SHIFT with no gap bit.
    - Otherwise go to IDLE. tx_active falls, which marks end of data to downstream.
  - **STUFF:** only exists with the macro; see Configuration.
- Bit order is LSB first: byte 0xA5 is sent as 1,0,1,0,0,1,0,1.
- Cycles with tx_enable=0 freeze sreg, bit_cnt, the ones counter and the state. The only exception is the IDLE-to-SHIFT transfer.
- Reset at any point (mid-byte, mid-stuff, or while the hold register is full) returns to IDLE and clears hold_full, sreg, bit_cnt and the ones counter. The partially sent byte and any held byte are discarded.

## Timing

- Latency from load acceptance to the first bit on Data_Out, when idle:
  - Edge N: the byte is accepted.
  - Edge N+1: the byte transfers to sreg and the state becomes SHIFT.
  - Data_Out is valid from edge N+1.
- Each bit persists until the next tx_enable=1 edge.
- load_ready rises the cycle after the transfer edge.
- With tx_enable held high continuously, back-to-back bytes stream without gaps, provided the source reloads within 7 cycles of load_ready rising.
- Data_Out, tx_active and stuff_bit are combinational functions of registered state only. No input reaches an output combinationally.

## Configuration

- Macro: TX_BIT_STUFF_EN.
- **Defined:**
  - A ones counter (0..6) counts consecutive transmitted 1s. It clears on any transmitted 0, on entering IDLE, and at reset.
  - On the tx_enable that retires the sixth consecutive 1, the bit is retired normally (shift and count advance) and the state goes to STUFF.
  - In STUFF: Data_Out=0, stuff_bit=1, tx_active=1, and sreg and bit_cnt are frozen.
  - On the next tx_enable, the ones counter clears. Then:
    - If that sixth 1 ended the byte, apply the end-of-byte rule (reload or IDLE).
    - Otherwise return to SHIFT.
  - A stuff bit is therefore emitted even after the final byte, before tx_active falls. Runs of ones span byte boundaries.
- **Undefined:** no ones counter and no STUFF state. stuff_bit is tied to 0, and the serial stream is the raw LSB-first data.

## Test plan

- Single byte, no stuffing:
  - Stimulus: load 0xA5 when idle, tx_enable=1 continuously.
  - Required: Data_Out = 1,0,1,0,0,1,0,1 over 8 cycles from edge N+1. tx_active is high for exactly 8 cycles, then 0. load_ready is back to 1 one cycle after the transfer edge.
- Back-to-back bytes:
  - Stimulus: load 0x01 then 0x80 with tx_enable=1 continuously.
  - Required: 16 contiguous bits, 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, with no idle cycle between bytes.
- Stuffing (TX_BIT_STUFF_EN defined):
  - Stimulus: load 0xFF then idle.
  - Required: Data_Out = 1,1,1,1,1,1,0,1,1. stuff_bit is high only on the 7th bit. tx_active is high for 9 cycles.
- No stuffing (TX_BIT_STUFF_EN undefined):
  - Stimulus: load 0xFF.
  - Required: eight 1s. stuff_bit stays 0 throughout.
- Sparse strobe:
  - Stimulus: load 0x3C with tx_enable high every 4th cycle.
  - Required: each bit is held exactly 4 cycles. The sequence is 0,0,1,1,1,1,0,0.
- Reset mid-byte:
  - Stimulus: assert Rst after 3 bits of 0x5A, with 0x77 held in the hold register.
  - Required: immediately Data_Out=0, tx_active=0, load_ready=1. After Rst is released, no residual bits are sent.

Source files
------------

// File: rtl/tx_shift_and_hold_reg.sv
// Transmit shift-and-hold register: one-entry hold buffer feeding an LSB-first serializer.
// Optional USB bit stuffing is enabled by defining TX_BIT_STUFF_EN.
module tx_shift_and_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              tx_shift_and_hold_reg_Clk,
    input  logic              tx_shift_and_hold_reg_Rst,
    input  logic [DATA_W-1:0] tx_shift_and_hold_reg_Data_In,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              tx_enable,
    output logic              tx_shift_and_hold_reg_Data_Out,
    output logic              tx_active,
    output logic              stuff_bit
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef TX_BIT_STUFF_EN
    typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_nxt;
    logic [DATA_W-1:0] hold, hold_nxt;
    logic              hold_full, hold_full_nxt;
    logic [DATA_W-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              accept;
    logic              byte_end;

`ifdef TX_BIT_STUFF_EN
    logic [2:0] ones_cnt, ones_nxt;
    // Remembers whether the sixth 1 was also the last bit of its byte.
    logic       stuff_eob, stuff_eob_nxt;
`endif

    assign accept = load_valid && !hold_full;

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        sreg_nxt      = sreg;
        bit_cnt_nxt   = bit_cnt;
        byte_end      = 1'b0;
`ifdef TX_BIT_STUFF_EN
        ones_nxt      = ones_cnt;
        stuff_eob_nxt = stuff_eob;
`endif

        if (accept) begin
            hold_nxt      = tx_shift_and_hold_reg_Data_In;
            hold_full_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
`ifdef TX_BIT_STUFF_EN
                ones_nxt = 3'd0;
`endif
                if (hold_full) begin
                    sreg_nxt      = hold;
                    bit_cnt_nxt   = '0;
                    hold_full_nxt = 1'b0;
                    state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                if (tx_enable) begin
                    sreg_nxt    = sreg >> 1;
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
`ifdef TX_BIT_STUFF_EN
                    ones_nxt = sreg[0] ? ones_cnt + 3'd1 : 3'd0;
                    if (sreg[0] && ones_cnt == 3'd5) begin
                        state_nxt     = STUFF;
                        stuff_eob_nxt = (bit_cnt == LAST_BIT);
                    end else begin
                        byte_end = (bit_cnt == LAST_BIT);
                    end
`else
                    byte_end = (bit_cnt == LAST_BIT);
`endif
                end
            end

`ifdef TX_BIT_STUFF_EN
            STUFF: begin
                if (tx_enable) begin
                    ones_nxt = 3'd0;
                    if (stuff_eob) begin
                        byte_end = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
`endif

            default: state_nxt = IDLE;
        endcase

        // A waiting byte reloads without a gap; otherwise the stream ends.
        if (byte_end) begin
            if (hold_full) begin
                sreg_nxt      = hold;
                bit_cnt_nxt   = '0;
                hold_full_nxt = 1'b0;
                state_nxt     = SHIFT;
            end else begin
                state_nxt = IDLE;
`ifdef TX_BIT_STUFF_EN
                ones_nxt  = 3'd0;
`endif
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tx_shift_and_hold_reg_Clk or posedge tx_shift_and_hold_reg_Rst) begin
        if (tx_shift_and_hold_reg_Rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            sreg      <= sreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

`ifdef TX_BIT_STUFF_EN
    always_ff @(posedge tx_shift_and_hold_reg_Clk or posedge tx_shift_and_hold_reg_Rst) begin
        if (tx_shift_and_hold_reg_Rst) begin
            ones_cnt  <= 3'd0;
            stuff_eob <= 1'b0;
        end else begin
            ones_cnt  <= ones_nxt;
            stuff_eob <= stuff_eob_nxt;
        end
    end
`endif

    // Outputs depend on registered state only.
    assign load_ready                     = !hold_full;
    assign tx_shift_and_hold_reg_Data_Out = (state == SHIFT) ? sreg[0] : 1'b0;
    assign tx_active                      = (state != IDLE);
`ifdef TX_BIT_STUFF_EN
    assign stuff_bit                      = (state == STUFF);
`else
    assign stuff_bit                      = 1'b0;
`endif

endmodule

// File: tb/tb_tx_shift_and_hold_reg.sv
// Directed bench for tx_shift_and_hold_reg; the stuffing scenario follows TX_BIT_STUFF_EN.
module tb_tx_shift_and_hold_reg;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       tx_en;
    logic       dout;
    logic       active;
    logic       stuff;

    int total = 0;
    int bad   = 0;

    tx_shift_and_hold_reg #(.DATA_W(8)) dut (
        .tx_shift_and_hold_reg_Clk      (clk),
        .tx_shift_and_hold_reg_Rst      (rst),
        .tx_shift_and_hold_reg_Data_In  (din),
        .load_valid                     (valid),
        .load_ready                     (ready),
        .tx_enable                      (tx_en),
        .tx_shift_and_hold_reg_Data_Out (dout),
        .tx_active                      (active),
        .stuff_bit                      (stuff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge on which the byte is accepted.
    task automatic load_byte(input logic [7:0] b);
        din   = b;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        tx_en = 1'b0;
        din   = 8'h00;
        repeat (3) step();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b want=0", dout); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
        total++; if (stuff !== 1'b0) begin bad++; $display("FAIL reset_stuff got=%b want=0", stuff); end
        rst = 1'b0;
        step();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL post_reset_active got=%b want=0", active); end
    endtask

    task automatic test_single_byte();
        logic [0:7] exp;
        exp   = 8'b10100101;
        tx_en = 1'b1;
        load_byte(8'hA5);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_ready_held got=%b want=0", ready); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL single_active_early got=%b want=0", active); end
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (dout !== exp[i]) begin bad++; $display("FAIL single_bit%0d got=%b want=%b", i, dout, exp[i]); end
            total++; if (active !== 1'b1) begin bad++; $display("FAIL single_active%0d got=%b want=1", i, active); end
            if (i == 0) begin
                total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready_back got=%b want=1", ready); end
            end
        end
        step();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL single_active_end got=%b want=0", active); end
        total++; if (dout !== 1'b0) begin bad++; $display("FAIL single_dout_end got=%b want=0", dout); end
    endtask

    task automatic test_back_to_back();
        logic [0:15] exp;
        exp   = 16'b1000_0000_0000_0001;
        tx_en = 1'b1;
        load_byte(8'h01);
        for (int i = 0; i < 16; i++) begin
            step();
            total++; if (dout !== exp[i]) begin bad++; $display("FAIL b2b_bit%0d got=%b want=%b", i, dout, exp[i]); end
            total++; if (active !== 1'b1) begin bad++; $display("FAIL b2b_active%0d got=%b want=1", i, active); end
            if (i == 1) begin
                total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full got=%b want=0", ready); end
            end
            if (i == 0) begin
                din   = 8'h80;
                valid = 1'b1;
            end else if (i == 1) begin
                valid = 1'b0;
            end
        end
        step();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL b2b_active_end got=%b want=0", active); end
    endtask

    task automatic test_all_ones();
        logic [0:8] exp_d;
        logic [0:8] exp_s;
        int         n;
`ifdef TX_BIT_STUFF_EN
        exp_d = 9'b111111011;
        exp_s = 9'b000000100;
        n     = 9;
`else
        exp_d = 9'b111111110;
        exp_s = 9'b000000000;
        n     = 8;
`endif
        tx_en = 1'b1;
        load_byte(8'hFF);
        for (int i = 0; i < n; i++) begin
            step();
            total++; if (dout !== exp_d[i]) begin bad++; $display("FAIL ones_bit%0d got=%b want=%b", i, dout, exp_d[i]); end
            total++; if (stuff !== exp_s[i]) begin bad++; $display("FAIL ones_stuff%0d got=%b want=%b", i, stuff, exp_s[i]); end
            total++; if (active !== 1'b1) begin bad++; $display("FAIL ones_active%0d got=%b want=1", i, active); end
        end
        step();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL ones_active_end got=%b want=0", active); end
        total++; if (stuff !== 1'b0) begin bad++; $display("FAIL ones_stuff_end got=%b want=0", stuff); end
    endtask

    task automatic test_sparse_strobe();
        logic [0:7] exp;
        exp   = 8'b00111100;
        tx_en = 1'b0;
        load_byte(8'h3C);
        for (int j = 0; j < 32; j++) begin
            step();
            total++; if (dout !== exp[j/4]) begin bad++; $display("FAIL sparse_cyc%0d got=%b want=%b", j, dout, exp[j/4]); end
            total++; if (active !== 1'b1) begin bad++; $display("FAIL sparse_active%0d got=%b want=1", j, active); end
            tx_en = ((j % 4) == 3);
        end
        step();
        tx_en = 1'b0;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL sparse_active_end got=%b want=0", active); end
    endtask

    task automatic test_reset_mid_byte();
        logic [0:7] exp;
        exp   = 8'b01011010;
        tx_en = 1'b1;
        load_byte(8'h5A);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (dout !== exp[i]) begin bad++; $display("FAIL mid_bit%0d got=%b want=%b", i, dout, exp[i]); end
            if (i == 0) begin
                din   = 8'h77;
                valid = 1'b1;
            end else if (i == 1) begin
                valid = 1'b0;
            end
        end
        step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_hold_full got=%b want=0", ready); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", active); end
        rst = 1'b1;
        #1;
        total++; if (dout !== 1'b0) begin bad++; $display("FAIL mid_rst_dout got=%b want=0", dout); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL mid_rst_active got=%b want=0", active); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ready); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++; if (active !== 1'b0) begin bad++; $display("FAIL mid_residual_active%0d got=%b want=0", i, active); end
            total++; if (dout !== 1'b0) begin bad++; $display("FAIL mid_residual_dout%0d got=%b want=0", i, dout); end
        end
        tx_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_all_ones();
        test_sparse_strobe();
        test_reset_mid_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
